mux4_arbiter: RTL and testbench
===============================

MUX4_ARBITER -- requirements
Module: mux4_arbiter

Interface
REQ-001 Parameter N, default 32, data width of every requester and of the output.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req_valid  input  4  bit i: requester i presents a beat.
REQ-005 req_lock  input  4  bit i: beat from requester i is not the last of a locked burst.
REQ-006 in_a, in_b, in_c, in_d  input  N each  data of requesters 0..3.
REQ-007 req_ready  output  4  one-hot or zero; bit i: beat of requester i accepted this cycle.
REQ-008 out_valid  output  1  out_data holds an unconsumed beat.
REQ-009 out_data  output  N  registered selected beat.
REQ-010 out_sel  output  2  index of the requester that supplied out_data.
REQ-011 out_ready  input  1  consumer takes the beat when out_valid and out_ready are both high.

Function
REQ-012 Output register is free when out_valid=0 or out_ready=1 in the same cycle ("accept slot").
REQ-013 In an accept slot with at least one eligible req_valid bit, exactly one requester g is granted: req_ready[g]=1 combinationally; on the next edge out_data<=in_g, out_sel<=g, out_valid<=1.
REQ-014 Latency: accepted beat appears on out_data exactly one cycle after acceptance; throughput one beat per cycle while out_ready=1.
REQ-015 With out_valid=1 and out_ready=0: req_ready=0, out_data/out_sel/out_valid held stable.
REQ-016 Accept slot with no eligible request: out_valid<=0 (if consumed), out_data and out_sel hold their values.
REQ-017 FSM state ARB: eligible = all requesters; winner = first set req_valid bit scanning from ptr upward, wrapping 3->0.
REQ-018 Round-robin pointer ptr (2 bits): on every accepted beat ptr<=g+1 mod 4 (3 wraps to 0); unchanged otherwise.
REQ-019 ARB -> LOCKED when accepted beat has req_lock[g]=1; owner<=g.
REQ-020 LOCKED: eligible = owner only; other req_valid bits ignored (req_ready for them stays 0) even if owner's req_valid=0.
REQ-021 LOCKED -> ARB when an owner beat is accepted with req_lock[owner]=0; ptr<=owner+1 mod 4 on that beat.
REQ-022 ptr does not advance on beats accepted in LOCKED state other than the burst-closing beat.
REQ-023 Simultaneous consume and accept in the same cycle is required (no bubble).
REQ-024 req_ready never asserts for a requester whose req_valid=0.

Reset
REQ-025 rst=1 at a clock edge: state<=ARB, ptr<=0, owner<=0, out_valid<=0, out_data<=0, out_sel<=0.
REQ-026 While rst=1, req_ready=0 combinationally; reset mid-burst or with a held beat drops that beat and clears the lock.

Structure
REQ-027 Shared package holds: FSM state encoding (ARB, LOCKED), default width constant N=32, requester count 4.
REQ-028 Data selection uses one instance of the existing 4:1 mux module mux4to1 (parameter N, select = winner index); arbitration logic and registers stay in mux4_arbiter.

Verification
REQ-029 Reset then req_valid=4'b1111, lock=0, out_ready=1 for 8 cycles -> grants 0,1,2,3,0,1,2,3; out_sel follows one cycle later.
REQ-030 ptr=2, req_valid=4'b0011 -> grant 0; next cycle ptr=1, req_valid=4'b0011 -> grant 1 (wrap-around).
REQ-031 Grant requester 1 with in_b=32'hDEADBEEF, then out_ready=0 for 3 cycles -> out_data=32'hDEADBEEF, out_valid=1, req_ready=0 throughout.
REQ-032 Requester 2 sends 3 beats with lock=1,1,0 while req_valid=4'b1111 -> three consecutive grants to 2, then grant 3.
REQ-033 LOCKED by owner 0, owner req_valid=0 for 2 cycles while others request -> req_ready=4'b0000, out_valid drops after consumption.
REQ-034 rst pulsed mid-burst with out_valid=1 -> next cycle out_valid=0, out_sel=0, out_data=0, state ARB, next grant from ptr=0.

Source files
------------

// File: rtl/mux4_arbiter_pkg.sv
// Shared definitions for the 4-requester round-robin arbiter with burst lock.
//   arb_state_t : arbitration FSM encoding (ARB = open round-robin,
//                 LOCKED = only the burst owner may be granted)
//   N_DEFAULT   : default data width of every requester and of the output
//   NUM_REQ     : number of requesters
//   rr_pick     : first set bit of a 4-bit request vector, scanning upward
//                 from a start index and wrapping 3 -> 0
package mux4_arbiter_pkg;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam int N_DEFAULT = 32;
    localparam int NUM_REQ   = 4;

    // Descending loop so the candidate closest to 'start' is written last
    // and therefore wins. With no bit set the result is 'start', which is
    // harmless because callers qualify it with the OR of the vector.
    function automatic logic [1:0] rr_pick(input logic [3:0] elig,
                                           input logic [1:0] start);
        logic [1:0] idx;
        rr_pick = start;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = start + 2'(k);
            if (elig[idx]) rr_pick = idx;
        end
    endfunction

endpackage

// File: rtl/mux4_arbiter_mux4to1.sv
// Plain 4:1 multiplexer, N bits wide.
//   sel        : 2-bit select
//   d0..d3     : data inputs
//   y          : selected data (combinational)
module mux4to1 #(
    parameter int N = 32
) (
    input  logic [1:0]   sel,
    input  logic [N-1:0] d0,
    input  logic [N-1:0] d1,
    input  logic [N-1:0] d2,
    input  logic [N-1:0] d3,
    output logic [N-1:0] y
);

    always_comb begin
        y = d0;
        case (sel)
            2'd0: y = d0;
            2'd1: y = d1;
            2'd2: y = d2;
            2'd3: y = d3;
            default: y = d0;
        endcase
    end

endmodule

// File: rtl/mux4_arbiter.sv
// Round-robin arbiter for four requesters feeding one registered output
// slot, with locked bursts: a beat flagged with req_lock keeps the grant
// on its requester until a beat without req_lock closes the burst.
//   clk, rst       : clock, synchronous active-high reset
//   req_valid[3:0] : requester i presents a beat
//   req_lock[3:0]  : beat of requester i is not the last of a locked burst
//   in_a..in_d     : data of requesters 0..3
//   req_ready[3:0] : one-hot/zero, beat of requester i accepted this cycle
//   out_valid      : out_data holds an unconsumed beat
//   out_data       : registered selected beat
//   out_sel        : index of the requester that supplied out_data
//   out_ready      : consumer takes the beat when out_valid && out_ready
module mux4_arbiter
    import mux4_arbiter_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   req_valid,
    input  logic [3:0]   req_lock,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic [N-1:0] in_c,
    input  logic [N-1:0] in_d,
    output logic [3:0]   req_ready,
    output logic         out_valid,
    output logic [N-1:0] out_data,
    output logic [1:0]   out_sel,
    input  logic         out_ready
);

    arb_state_t   state, state_nxt;
    logic [1:0]   ptr, ptr_nxt;
    logic [1:0]   owner, owner_nxt;

    logic         accept_slot;
    logic [3:0]   eligible;
    logic [1:0]   winner;
    logic         grant;
    logic [N-1:0] mux_y;

    // The output register can take a new beat whenever it is empty or is
    // being drained this very cycle, so a full-rate stream has no bubble.
    assign accept_slot = !out_valid || out_ready;

    // While locked, only the owner may win, even if it is idle this cycle.
    assign eligible  = (state == LOCKED) ? (req_valid & (4'b0001 << owner))
                                         : req_valid;
    assign winner    = (state == LOCKED) ? owner : rr_pick(eligible, ptr);
    assign grant     = !rst && accept_slot && (|eligible);
    assign req_ready = grant ? (4'b0001 << winner) : 4'b0000;

    mux4to1 #(.N(N)) u_mux (
        .sel (winner),
        .d0  (in_a),
        .d1  (in_b),
        .d2  (in_c),
        .d3  (in_d),
        .y   (mux_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB;
            ptr   <= 2'd0;
            owner <= 2'd0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            owner <= owner_nxt;
        end
    end

    // The pointer moves on every open-arbitration beat (including the one
    // that opens a burst) and on the closing beat of a burst, never on the
    // middle beats.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        owner_nxt = owner;
        if (grant) begin
            case (state)
                ARB: begin
                    ptr_nxt = winner + 2'd1;
                    if (req_lock[winner]) begin
                        state_nxt = LOCKED;
                        owner_nxt = winner;
                    end
                end
                LOCKED: begin
                    if (!req_lock[winner]) begin
                        state_nxt = ARB;
                        ptr_nxt   = owner + 2'd1;
                    end
                end
                default: state_nxt = ARB;
            endcase
        end
    end

    // Output stage: one register slot between the grant and the consumer.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= 2'd0;
        end else if (accept_slot) begin
            out_valid <= grant;
            if (grant) begin
                out_data <= mux_y;
                out_sel  <= winner;
            end
        end
    end

endmodule

// File: tb/tb_mux4_arbiter.sv
module tb_mux4_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_lock;
    logic [31:0] in_a, in_b, in_c, in_d;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic [1:0]  out_sel;
    logic        out_ready;

    int total  = 0;
    int passed = 0;

    // Reference model: arbitration pointer, lock owner and the output slot.
    int          m_ptr, m_owner, m_os, m_g;
    bit          m_locked, m_ov;
    logic [31:0] m_od;

    always #5 clk = ~clk;

    mux4_arbiter #(.N(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_lock  (req_lock),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_c      (in_c),
        .in_d      (in_d),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] data_of(input int g);
        case (g)
            0: return in_a;
            1: return in_b;
            2: return in_c;
            default: return in_d;
        endcase
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_owner = 0; m_locked = 0;
        m_ov = 0; m_od = 32'h0; m_os = 0;
    endtask

    // Who should be granted this cycle: scan from the pointer with wrap,
    // restricted to the owner during a burst.
    task automatic model_comb();
        int idx;
        m_g = -1;
        if (!rst && (!m_ov || out_ready)) begin
            for (int k = 0; k < 4; k++) begin
                idx = (m_ptr + k) % 4;
                if (m_g < 0 && req_valid[idx] && (!m_locked || idx == m_owner))
                    m_g = idx;
            end
        end
    endtask

    task automatic model_update();
        if (rst) begin
            model_reset();
        end else if (!m_ov || out_ready) begin
            m_ov = (m_g >= 0);
            if (m_g >= 0) begin
                m_od = data_of(m_g);
                m_os = m_g;
                if (!m_locked) begin
                    m_ptr = (m_g + 1) % 4;
                    if (req_lock[m_g]) begin
                        m_locked = 1;
                        m_owner  = m_g;
                    end
                end else if (!req_lock[m_g]) begin
                    m_locked = 0;
                    m_ptr    = (m_owner + 1) % 4;
                end
            end
        end
    endtask

    // One clock cycle with the currently driven inputs. want_g: -2 = only
    // the model decides, -1 = no grant required, 0..3 = that grant required.
    task automatic step(input string tag, input int want_g);
        logic [3:0]  exp_ready;
        logic [31:0] want_vec;
        #1;
        model_comb();
        exp_ready = (m_g >= 0) ? (4'b0001 << m_g) : 4'b0000;
        check({tag, "/ready"}, 32'(req_ready), 32'(exp_ready));
        if (want_g != -2) begin
            want_vec = (want_g < 0) ? 32'd0 : (32'd1 << want_g);
            check({tag, "/grant"}, 32'(req_ready), want_vec);
        end
        check({tag, "/out_valid"}, 32'(out_valid), 32'(m_ov));
        check({tag, "/out_sel"}, 32'(out_sel), 32'(m_os));
        check({tag, "/out_data"}, out_data, m_od);
        @(posedge clk);
        model_update();
        #1;
    endtask

    initial begin
        rst = 1'b1; req_valid = 4'h0; req_lock = 4'h0; out_ready = 1'b0;
        in_a = 32'hA0A0_0000; in_b = 32'hB0B0_0001;
        in_c = 32'hC0C0_0002; in_d = 32'hD0D0_0003;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;
        check("reset/out_valid", 32'(out_valid), 32'd0);
        check("reset/out_sel", 32'(out_sel), 32'd0);
        check("reset/out_data", out_data, 32'd0);
        check("reset/req_ready_idle", 32'(req_ready), 32'd0);

        // Full round-robin rotation with every requester active.
        req_valid = 4'b1111; out_ready = 1'b1;
        for (int i = 0; i < 8; i++) step("rr_rotate", i % 4);
        req_valid = 4'b0000;
        step("rr_drain", -1);

        // Pointer at 2 then wrap: grant 1 alone moves ptr to 2.
        req_valid = 4'b0010;
        step("wrap_setup", 1);
        req_valid = 4'b0011;
        step("wrap_from2", 0);
        step("wrap_from1", 1);
        req_valid = 4'b0000;
        step("wrap_drain", -1);

        // Back-pressure holds the registered beat stable.
        in_b = 32'hDEADBEEF; req_valid = 4'b0010;
        step("hold_grant", -2);
        out_ready = 1'b0; req_valid = 4'b1111; in_b = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            step("hold", -1);
            check("hold/data_const", out_data, 32'hDEADBEEF);
            check("hold/valid_const", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1; req_valid = 4'b0000;
        step("hold_release", -1);

        // Locked burst from requester 2 among four active requesters.
        rst = 1'b1; step("rst2", -1); rst = 1'b0;
        req_valid = 4'b1111; req_lock = 4'b0000;
        step("burst_pre0", 0);
        step("burst_pre1", 1);
        req_lock = 4'b0100;
        step("burst_b0", 2);
        step("burst_b1", 2);
        req_lock = 4'b0000;
        step("burst_b2", 2);
        step("burst_after", 3);
        req_valid = 4'b0000;
        step("burst_drain", -1);

        // Locked by owner 0 while the owner goes idle.
        rst = 1'b1; step("rst3", -1); rst = 1'b0;
        req_valid = 4'b0001; req_lock = 4'b0001;
        step("lock0_open", 0);
        req_valid = 4'b1110;
        step("lock0_idle0", -1);
        step("lock0_idle1", -1);
        check("lock0/out_valid_drop", 32'(out_valid), 32'd0);
        req_valid = 4'b1111; req_lock = 4'b0000;
        step("lock0_close", 0);
        step("lock0_next", 1);

        // Reset mid-burst with a held beat.
        req_valid = 4'b0100; req_lock = 4'b0100;
        step("midrst_open", 2);
        out_ready = 1'b0; req_valid = 4'b1111;
        step("midrst_hold", -1);
        rst = 1'b1;
        step("midrst_rst", -1);
        rst = 1'b0;
        check("midrst/out_valid", 32'(out_valid), 32'd0);
        check("midrst/out_sel", 32'(out_sel), 32'd0);
        check("midrst/out_data", out_data, 32'd0);
        out_ready = 1'b1; req_lock = 4'b0000;
        step("midrst_first", 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            req_valid = 4'($urandom);
            req_lock  = 4'($urandom);
            out_ready = ($urandom % 4) != 0;
            in_a = $urandom; in_b = $urandom; in_c = $urandom; in_d = $urandom;
            rst = ($urandom % 50) == 0;
            step("rand", -2);
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
